// File: rtl/serial_operand_feeder_if.sv
// serial_operand_feeder_if
//   Bundles the operand handshake and the serial bit-pair stream of the
//   serial operand feeder.
//   master : upstream producer side (drives in_valid/in_a/in_b, observes the rest)
//   slave  : the feeder itself
//   Signals:
//     in_valid, in_ready, in_a, in_b  - operand pair handshake
//     adder_clr                       - clear pulse for the serial adder carry
//     ser_a, ser_b, ser_valid         - serial bit pair, LSB first
//     ser_first, ser_last             - frame boundary markers
//     busy, done                      - operation status
interface serial_operand_feeder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             adder_clr;
  logic             ser_a;
  logic             ser_b;
  logic             ser_valid;
  logic             ser_first;
  logic             ser_last;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_a, in_b,
    input  in_ready, adder_clr, ser_a, ser_b, ser_valid,
           ser_first, ser_last, busy, done
  );

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready, adder_clr, ser_a, ser_b, ser_valid,
           ser_first, ser_last, busy, done
  );
endinterface

// File: rtl/serial_operand_feeder.sv
// serial_operand_feeder
//   Upstream stage of the bit-serial adder. Accepts a WIDTH-bit operand pair
//   through a valid/ready handshake, pulses adder_clr for one cycle, then
//   streams the operands LSB first one bit pair per clock, optionally followed
//   by FLUSH zero pad pairs so the final carry shows up in the sum stream.
//   Ports:
//     clk    - rising-edge clock
//     reset  - asynchronous, active-high reset
//     bus    - serial_operand_feeder_if slave modport (handshake + serial stream)
//   Every output except in_ready is registered; in_ready is decoded from the
//   IDLE state.
module serial_operand_feeder #(
  parameter int WIDTH = 8,
  parameter int FLUSH = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  serial_operand_feeder_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    SHIFT = 3'd2,
    PAD   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sh_a_q, sh_a_d;
  logic [WIDTH-1:0]   sh_b_q, sh_b_d;
  logic               adder_clr_q, adder_clr_d;
  logic               ser_a_q, ser_a_d;
  logic               ser_b_q, ser_b_d;
  logic               ser_valid_q, ser_valid_d;
  logic               ser_first_q, ser_first_d;
  logic               ser_last_q, ser_last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // The output registers are loaded with the values belonging to the state
  // being entered, so each output lines up with its state cycle while staying
  // glitch-free. The shift registers advance whenever a bit is emitted, so
  // sh_*_q[0] always holds the next bit to send.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    adder_clr_d = 1'b0;
    ser_a_d     = 1'b0;
    ser_b_d     = 1'b0;
    ser_valid_d = 1'b0;
    ser_first_d = 1'b0;
    ser_last_d  = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sh_a_d      = bus.in_a;
          sh_b_d      = bus.in_b;
          adder_clr_d = 1'b1;
          state_d     = CLR;
        end
      end

      CLR: begin
        cnt_d       = '0;
        ser_a_d     = sh_a_q[0];
        ser_b_d     = sh_b_q[0];
        ser_valid_d = 1'b1;
        ser_first_d = 1'b1;
        sh_a_d      = sh_a_q >> 1;
        sh_b_d      = sh_b_q >> 1;
        state_d     = SHIFT;
      end

      SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          if (FLUSH != 0) begin
            ser_valid_d = 1'b1;
            ser_last_d  = 1'b1;
            state_d     = PAD;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
          ser_a_d     = sh_a_q[0];
          ser_b_d     = sh_b_q[0];
          ser_valid_d = 1'b1;
          // Without padding the operand MSB closes the frame.
          ser_last_d  = (FLUSH == 0) && (cnt_q == CNT_PENULT);
          sh_a_d      = sh_a_q >> 1;
          sh_b_d      = sh_b_q >> 1;
        end
      end

      PAD: begin
        done_d  = 1'b1;
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // All state and output registers; reset returns everything to an idle,
  // all-zero frame and drops any captured operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      adder_clr_q <= 1'b0;
      ser_a_q     <= 1'b0;
      ser_b_q     <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_first_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      adder_clr_q <= adder_clr_d;
      ser_a_q     <= ser_a_d;
      ser_b_q     <= ser_b_d;
      ser_valid_q <= ser_valid_d;
      ser_first_q <= ser_first_d;
      ser_last_q  <= ser_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.adder_clr = adder_clr_q;
  assign bus.ser_a     = ser_a_q;
  assign bus.ser_b     = ser_b_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_first = ser_first_q;
  assign bus.ser_last  = ser_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_serial_operand_feeder.sv
// tb_serial_operand_feeder
//   Bench for serial_operand_feeder. Two instances are exercised: dut1 with
//   WIDTH=8/FLUSH=1 and dut0 with WIDTH=8/FLUSH=0. A reference model turns
//   each accepted operand pair into the expected per-cycle output table of the
//   frame (clear, operand bits, optional pad, done) and compares every cycle;
//   the serial stream is also summed bit-serially and checked against a+b.
module tb_serial_operand_feeder;

  localparam int W = 8;
  localparam int SPACING1 = 2 + W + 1 + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;

  serial_operand_feeder_if #(.WIDTH(W)) bus1 ();
  serial_operand_feeder_if #(.WIDTH(W)) bus0 ();

  serial_operand_feeder #(.WIDTH(W), .FLUSH(1)) dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1)
  );

  serial_operand_feeder #(.WIDTH(W), .FLUSH(0)) dut0 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus0)
  );

  always #5 clk = ~clk;

  // Expected output vectors, one per upcoming cycle, bit order
  // {adder_clr, ser_a, ser_b, ser_valid, ser_first, ser_last, busy, done}.
  logic [7:0]  q1[$];
  logic [7:0]  q0[$];
  logic [15:0] op1[$];
  logic [15:0] op0[$];
  int          xfer1[$];
  int          cyc1 = 0;

  // Counts every comparison and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] bitVec(input logic a, input logic b, input bit first, input bit last);
    return {1'b0, a, b, 1'b1, first, last, 1'b1, 1'b0};
  endfunction

  // Reference model for dut1: an empty queue means IDLE, so a valid seen at
  // that edge is a transfer and expands into the whole frame table.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q1.delete();
      op1.delete();
    end else begin
      cyc1++;
      if (q1.size() == 0) begin
        if (bus1.in_valid) begin
          q1.push_back(8'b1000_0010);
          for (int i = 0; i < W; i++)
            q1.push_back(bitVec(bus1.in_a[i], bus1.in_b[i], i == 0, 1'b0));
          q1.push_back(8'b0001_0110);
          q1.push_back(8'b0000_0011);
          op1.push_back({bus1.in_a, bus1.in_b});
          xfer1.push_back(cyc1);
        end
      end else begin
        void'(q1.pop_front());
      end
    end
  end

  // Reference model for dut0: no pad, last marker on the operand MSB.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q0.delete();
      op0.delete();
    end else begin
      if (q0.size() == 0) begin
        if (bus0.in_valid) begin
          q0.push_back(8'b1000_0010);
          for (int i = 0; i < W; i++)
            q0.push_back(bitVec(bus0.in_a[i], bus0.in_b[i], i == 0, i == W - 1));
          q0.push_back(8'b0000_0011);
          op0.push_back({bus0.in_a, bus0.in_b});
        end
      end else begin
        void'(q0.pop_front());
      end
    end
  end

  // Per-cycle comparison plus a bit-serial adder fed from each stream.
  logic [8:0] s1, s0;
  logic       c1, c0;
  int         i1, i0;

  always @(negedge clk) begin
    logic [7:0] ea, eb;
    logic [8:0] e9;
    logic [7:0] e8;
    checkOutput("dut1_outs", 32'({bus1.adder_clr, bus1.ser_a, bus1.ser_b, bus1.ser_valid,
                                  bus1.ser_first, bus1.ser_last, bus1.busy, bus1.done}),
                32'((q1.size() != 0) ? q1[0] : 8'h00));
    checkOutput("dut1_ready", 32'(bus1.in_ready), 32'(q1.size() == 0));
    checkOutput("dut0_outs", 32'({bus0.adder_clr, bus0.ser_a, bus0.ser_b, bus0.ser_valid,
                                  bus0.ser_first, bus0.ser_last, bus0.busy, bus0.done}),
                32'((q0.size() != 0) ? q0[0] : 8'h00));
    checkOutput("dut0_ready", 32'(bus0.in_ready), 32'(q0.size() == 0));

    if (reset || bus1.adder_clr) begin s1 = '0; c1 = 1'b0; i1 = 0; end
    if (bus1.ser_valid && i1 < 9) begin
      s1[i1] = bus1.ser_a ^ bus1.ser_b ^ c1;
      c1 = (bus1.ser_a & bus1.ser_b) | (c1 & (bus1.ser_a ^ bus1.ser_b));
      i1++;
    end
    if (bus1.done && op1.size() != 0) begin
      {ea, eb} = op1.pop_front();
      e9 = {1'b0, ea} + {1'b0, eb};
      checkOutput("dut1_sum", 32'(s1), 32'(e9));
    end

    if (reset || bus0.adder_clr) begin s0 = '0; c0 = 1'b0; i0 = 0; end
    if (bus0.ser_valid && i0 < 8) begin
      s0[i0] = bus0.ser_a ^ bus0.ser_b ^ c0;
      c0 = (bus0.ser_a & bus0.ser_b) | (c0 & (bus0.ser_a ^ bus0.ser_b));
      i0++;
    end
    if (bus0.done && op0.size() != 0) begin
      {ea, eb} = op0.pop_front();
      e8 = ea + eb;
      checkOutput("dut0_sum", 32'(s0), 32'({1'b0, e8}));
    end
  end

  task automatic driveIn(input bit sel, input logic v, input logic [7:0] a, input logic [7:0] b);
    if (sel) begin
      bus1.in_valid = v; bus1.in_a = a; bus1.in_b = b;
    end else begin
      bus0.in_valid = v; bus0.in_a = a; bus0.in_b = b;
    end
  endtask

  // Presents an operand pair and waits until it is accepted; returns at the
  // falling edge inside the CLR cycle.
  task automatic applyStimulus(input bit sel, input logic [7:0] a, input logic [7:0] b, input bit keepValid);
    int waitCnt = 0;
    @(negedge clk);
    driveIn(sel, 1'b1, a, b);
    while (!(sel ? bus1.in_ready : bus0.in_ready) && waitCnt < 60) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("accept_wait", 32'(waitCnt < 60), 32'd1);
    @(negedge clk);
    if (!keepValid) driveIn(sel, 1'b0, 8'($urandom), 8'($urandom));
  endtask

  task automatic waitIdle(input bit sel);
    int waitCnt = 0;
    while (((sel ? q1.size() : q0.size()) != 0) && waitCnt < 40) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("frame_wait", 32'(waitCnt < 40), 32'd1);
  endtask

  initial begin
    int n;
    driveIn(1'b1, 1'b0, 8'h00, 8'h00);
    driveIn(1'b0, 1'b0, 8'h00, 8'h00);

    // Reset values.
    #1;
    checkOutput("reset_outs1", 32'({bus1.adder_clr, bus1.ser_a, bus1.ser_b, bus1.ser_valid,
                                    bus1.ser_first, bus1.ser_last, bus1.busy, bus1.done}), 32'd0);
    checkOutput("reset_ready1", 32'(bus1.in_ready), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Carry propagates into the pad bit.
    applyStimulus(1'b1, 8'hFF, 8'h01, 1'b0);
    waitIdle(1'b1);

    // Mixed bit pattern.
    applyStimulus(1'b1, 8'h5A, 8'h3C, 1'b0);
    waitIdle(1'b1);

    // No pad: last marker on bit 7.
    applyStimulus(1'b0, 8'hA5, 8'h0F, 1'b0);
    waitIdle(1'b0);

    // Valid held high across three pairs: transfers spaced by a full frame.
    n = xfer1.size();
    applyStimulus(1'b1, 8'h81, 8'h7F, 1'b1);
    applyStimulus(1'b1, 8'h33, 8'hCC, 1'b1);
    applyStimulus(1'b1, 8'hF0, 8'h1E, 1'b0);
    waitIdle(1'b1);
    checkOutput("b2b_count", 32'(xfer1.size() - n), 32'd3);
    if (xfer1.size() - n == 3) begin
      checkOutput("b2b_gap1", 32'(xfer1[n+1] - xfer1[n]), 32'(SPACING1));
      checkOutput("b2b_gap2", 32'(xfer1[n+2] - xfer1[n+1]), 32'(SPACING1));
    end

    // Asynchronous reset in the cnt=3 cycle: everything drops at once and the
    // aborted frame never reports done.
    applyStimulus(1'b1, 8'hC3, 8'h96, 1'b0);
    repeat (4) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("abort_outs1", 32'({bus1.adder_clr, bus1.ser_a, bus1.ser_b, bus1.ser_valid,
                                    bus1.ser_first, bus1.ser_last, bus1.busy, bus1.done}), 32'd0);
    checkOutput("abort_ready1", 32'(bus1.in_ready), 32'd1);
    @(negedge clk);
    #1 reset = 1'b0;
    applyStimulus(1'b1, 8'h6D, 8'hB7, 1'b0);
    waitIdle(1'b1);

    // Operand and valid noise during a frame is ignored.
    applyStimulus(1'b1, 8'h2E, 8'hD9, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      driveIn(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end
    driveIn(1'b1, 1'b0, 8'h00, 8'h00);
    waitIdle(1'b1);

    // Random frames on both instances.
    for (int k = 0; k < 16; k++) begin
      applyStimulus(k[0], 8'($urandom), 8'($urandom), 1'b0);
      repeat ($urandom_range(0, 14)) @(negedge clk);
    end
    waitIdle(1'b1);
    waitIdle(1'b0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_operand_feeder.md
Name: serial_operand_feeder

Overview:
Upstream stage of the bit-serial adder FSM. Accepts a pair of WIDTH-bit operands through a valid/ready handshake and emits them LSB-first, one bit pair per clock, on the adder's a/b inputs. Before each operation it pulses a clear so the adder's carry state returns to zero. After the operand bits it optionally appends zero pad bits, so the final carry appears as the MSB of the sum stream.

Parameters:
WIDTH, 8, operand width in bits (>=2)
FLUSH, 1, number of zero pad bit-pairs appended after the operands to drain the carry (0 or 1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  feeder idle, can accept an operand pair
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
adder_clr  output  1  one-cycle clear pulse to the serial adder state register
ser_a  output  1  current serial bit of A
ser_b  output  1  current serial bit of B
ser_valid  output  1  ser_a/ser_b carry a meaningful bit pair this cycle
ser_first  output  1  marks the bit-0 cycle
ser_last  output  1  marks the final bit cycle of the frame (operand MSB or pad bit)
busy  output  1  operation in progress (state != IDLE)
done  output  1  one-cycle pulse after the frame completes

Behaviour:
- Reset: clk and reset as already decided — reset is asynchronous, active-high; clock is clk. While reset is asserted:
  - state = IDLE, in_ready = 1.
  - adder_clr, ser_a, ser_b, ser_valid, ser_first, ser_last, busy and done are all 0.
  - Shift registers and counter are cleared.
- Output timing: all outputs except in_ready are registered, so adder_clr is glitch-free for the adder's async reset. in_ready is decoded directly from state == IDLE.
- Handshake:
  - Transfer occurs on a rising edge where in_valid && in_ready.
  - in_a/in_b are captured into shift registers sh_a/sh_b on that edge.
  - in_valid outside IDLE is ignored.
  - in_a/in_b changes after capture have no effect.
- FSM states (cycle counts start at the cycle after transfer):
  - IDLE: in_ready=1. On transfer go to CLR.
  - CLR (1 cycle): adder_clr=1, ser_valid=0, ser_a=ser_b=0. Go to SHIFT.
  - SHIFT (WIDTH cycles, counter cnt 0..WIDTH-1):
    - ser_a=sh_a[0], ser_b=sh_b[0], ser_valid=1; both registers shift right each cycle.
    - ser_first=1 when cnt=0.
    - ser_last=1 when cnt=WIDTH-1 and FLUSH=0.
    - At cnt=WIDTH-1, go to PAD if FLUSH=1, else DONE.
  - PAD (FLUSH cycles): ser_a=ser_b=0, ser_valid=1, ser_last=1. Go to DONE.
  - DONE (1 cycle): done=1, ser_valid=0, ser_a=ser_b=0. Go to IDLE.
- Latency: first operand bit appears 2 cycles after the transfer edge. busy is high for 1+WIDTH+FLUSH+1 cycles.
- Throughput: the earliest next transfer is in the IDLE cycle following DONE. Consecutive frames are therefore separated by exactly one IDLE cycle plus one CLR cycle, with no overlap.
- Counter width: cnt is clog2(WIDTH) bits. It resets to 0 on entry to SHIFT and never wraps within a frame.
- Reset mid-operation: immediate return to IDLE with the reset values above. done is never issued for the aborted frame, and the captured operands are discarded.
- ser_a/ser_b are 0 whenever ser_valid=0, so the downstream adder sees a=b=0 (carry-holding input) outside frames.
- Illegal/unused state encodings return to IDLE on the next clock.

Test Plan:
1. WIDTH=8, FLUSH=1, in_a=0xFF, in_b=0x01, single transfer -> 1 CLR cycle with adder_clr=1, then ser_a=1,1,1,1,1,1,1,1,0 and ser_b=1,0,0,0,0,0,0,0,0. Adder sum stream reconstructs to 9'h100. done pulses 11 cycles after transfer.
2. WIDTH=8, FLUSH=1, in_a=0x5A, in_b=0x3C -> ser_first on cycle of bit 0, ser_last only on pad cycle. Reconstructed sum = 9'h096. busy high exactly 11 cycles.
3. FLUSH=0, in_a=0xA5, in_b=0x0F -> 8 ser_valid cycles, ser_last on bit 7, no pad cycle, done 10 cycles after transfer.
4. in_valid held high with three different operand pairs presented back-to-back -> each accepted only when in_ready=1. Transfers are spaced exactly 2+WIDTH+FLUSH+1 cycles apart, and all three sums are correct.
5. Reset asserted mid-SHIFT (cnt=3) -> all outputs 0 and in_ready=1 asynchronously. No done pulse; the next transfer after reset produces a correct frame.
6. in_a/in_b toggled randomly and in_valid pulsed during SHIFT -> serial stream unchanged and no extra transfer.
